dma_benchmark_monitor: RTL

//  Passive observer on the engine side of the benchmark descriptor path. Watches engine-valid and
//  the control byte returned per DMA operation, and times every iteration (start/EOP to next EOP).

---
 rtl/dma_benchmark_monitor_if.sv | 29 ++
 rtl/dma_benchmark_monitor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/dma_benchmark_monitor_if.sv
// Engine-side observation bus for the DMA benchmark monitor: engine status in, statistics out.
interface dma_benchmark_monitor_if #(
  parameter int unsigned C_LAT_WIDTH = 32
);
  logic                   engine_valid;
  logic [7:0]             control_byte;
  logic [63:0]            size_at_descriptor;
  logic                   clear;
  logic                   busy;
  logic                   result_valid;
  logic                   timeout;
  logic [63:0]            iter_count;
  logic [63:0]            total_cycles;
  logic [63:0]            total_bytes;
  logic [C_LAT_WIDTH-1:0] min_cycles;
  logic [C_LAT_WIDTH-1:0] max_cycles;

  modport master (
    output engine_valid, control_byte, size_at_descriptor, clear,
    input  busy, result_valid, timeout, iter_count, total_cycles, total_bytes,
           min_cycles, max_cycles
  );

  modport slave (
    input  engine_valid, control_byte, size_at_descriptor, clear,
    output busy, result_valid, timeout, iter_count, total_cycles, total_bytes,
           min_cycles, max_cycles
  );
endinterface

// File: rtl/dma_benchmark_monitor.sv
// Passive benchmark monitor: times each iteration between start/EOP events and accumulates
// count, total/min/max latency and bytes; results freeze in DONE for consistent host readback.
module dma_benchmark_monitor #(
  parameter int unsigned C_EOP_BIT        = 3,
  parameter int unsigned C_LAT_WIDTH      = 32,
  parameter int unsigned C_TIMEOUT_CYCLES = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  dma_benchmark_monitor_if.slave  mon
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [C_LAT_WIDTH-1:0] LAT_ONE = C_LAT_WIDTH'(1);
  localparam logic [C_LAT_WIDTH-1:0] LAT_MAX = {C_LAT_WIDTH{1'b1}};
  localparam logic [C_LAT_WIDTH-1:0] LAT_TMO = C_LAT_WIDTH'(C_TIMEOUT_CYCLES);
  localparam bit                     TMO_EN  = (C_TIMEOUT_CYCLES != 0);
  localparam logic [7:0]             EOP_MSK = 8'(1) << C_EOP_BIT;

  state_e                 state_q, state_d;
  logic                   valid_q;
  logic [C_LAT_WIDTH-1:0] cur_q, cur_d;
  logic [C_LAT_WIDTH-1:0] min_q, min_d;
  logic [C_LAT_WIDTH-1:0] max_q, max_d;
  logic [C_LAT_WIDTH-1:0] min_out_q, min_out_d;
  logic [63:0]            iter_q, iter_d;
  logic [63:0]            tcyc_q, tcyc_d;
  logic [63:0]            tbytes_q, tbytes_d;
  logic                   timeout_q, timeout_d;
  logic                   busy_q, busy_d;
  logic                   rvalid_q, rvalid_d;

  logic rise, eop, start, clr, eop_hit, tmo_hit;

  // Event decode; a start always beats CLEAR, and CLEAR always beats EOP.
  assign rise    = mon.engine_valid & ~valid_q;
  assign eop     = |(mon.control_byte & EOP_MSK);
  assign start   = rise && (state_q != S_RUN);
  assign clr     = mon.clear && !start;
  assign eop_hit = (state_q == S_RUN) && eop && !clr;
  assign tmo_hit = TMO_EN && (state_q == S_RUN) && !eop && !clr && (cur_q == LAT_TMO);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (!mon.engine_valid || tmo_hit) state_d = S_DONE;
      S_DONE: begin
        if (start)    state_d = S_RUN;
        else if (clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Statistics and output next values
  always_comb begin
    cur_d     = cur_q;
    min_d     = min_q;
    max_d     = max_q;
    iter_d    = iter_q;
    tcyc_d    = tcyc_q;
    tbytes_d  = tbytes_q;
    timeout_d = timeout_q;
    if (start || clr) begin
      if (start || state_q == S_RUN) cur_d = LAT_ONE;
      min_d     = LAT_MAX;
      max_d     = '0;
      iter_d    = '0;
      tcyc_d    = '0;
      tbytes_d  = '0;
      timeout_d = 1'b0;
    end else if (eop_hit) begin
      cur_d    = LAT_ONE;
      iter_d   = iter_q + 64'(1);
      tcyc_d   = tcyc_q + 64'(cur_q);
      tbytes_d = tbytes_q + mon.size_at_descriptor;
      if (cur_q < min_q) min_d = cur_q;
      if (cur_q > max_q) max_d = cur_q;
    end else if (state_q == S_RUN) begin
      if (cur_q != LAT_MAX) cur_d = cur_q + LAT_ONE;
      if (tmo_hit) timeout_d = 1'b1;
    end
    min_out_d = (iter_d == 64'(0)) ? '0 : min_d;
    busy_d    = (state_d == S_RUN);
    rvalid_d  = (state_d == S_DONE);
  end

  // valid_q resets high so a level already present at reset release is not a start
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b1;
      cur_q     <= '0;
      min_q     <= LAT_MAX;
      max_q     <= '0;
      min_out_q <= '0;
      iter_q    <= '0;
      tcyc_q    <= '0;
      tbytes_q  <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      valid_q   <= mon.engine_valid;
      cur_q     <= cur_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_out_q <= min_out_d;
      iter_q    <= iter_d;
      tcyc_q    <= tcyc_d;
      tbytes_q  <= tbytes_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign mon.busy         = busy_q;
  assign mon.result_valid = rvalid_q;
  assign mon.timeout      = timeout_q;
  assign mon.iter_count   = iter_q;
  assign mon.total_cycles = tcyc_q;
  assign mon.total_bytes  = tbytes_q;
  assign mon.min_cycles   = min_out_q;
  assign mon.max_cycles   = max_q;

endmodule
